// File: rtl/mem_port_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_if
//
// Bundles every handshake and bus signal around the memory port arbiter:
// the CPU fetch port, the CPU data port, the stall line, the shared memory
// port and the sticky error flag. Clock and reset are not part of the bundle.
//
// Parameter
//   ADDR_W     memory byte-address width
//
// Signals (direction as seen by the arbiter)
//   if_req     in   fetch request
//   if_addr    in   fetch address
//   if_rdata   out  fetched instruction word
//   if_ack     out  fetch-complete pulse
//   d_read     in   data read request
//   d_write    in   data write request
//   d_addr     in   data address
//   d_wdata    in   data write byte
//   d_rdata    out  data read byte
//   d_ack      out  data-complete pulse
//   stall      out  CPU hold while any request is unacknowledged
//   mem_read   out  memory read strobe
//   mem_write  out  memory write strobe
//   mem_addr   out  memory address
//   mem_wdata  out  memory write byte
//   mem_rdata  in   memory read word
//   mem_busy   in   memory still working on the current access
//   err        out  sticky timeout flag
//
// Modports
//   slave      the arbiter itself
//   master     the environment around it (CPU plus memory)
// -----------------------------------------------------------------------------
interface mem_port_arbiter_if #(
   parameter int ADDR_W = 10
);
   // Fetch port
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic [31:0]       if_rdata;
   logic              if_ack;

   // Data port
   logic              d_read;
   logic              d_write;
   logic [ADDR_W-1:0] d_addr;
   logic [7:0]        d_wdata;
   logic [7:0]        d_rdata;
   logic              d_ack;

   // CPU hold
   logic              stall;

   // Shared memory port
   logic              mem_read;
   logic              mem_write;
   logic [ADDR_W-1:0] mem_addr;
   logic [7:0]        mem_wdata;
   logic [31:0]       mem_rdata;
   logic              mem_busy;

   // Status
   logic              err;

   modport slave (
      input  if_req, if_addr,
      input  d_read, d_write, d_addr, d_wdata,
      input  mem_rdata, mem_busy,
      output if_rdata, if_ack,
      output d_rdata, d_ack,
      output stall,
      output mem_read, mem_write, mem_addr, mem_wdata,
      output err
   );

   modport master (
      output if_req, if_addr,
      output d_read, d_write, d_addr, d_wdata,
      output mem_rdata, mem_busy,
      input  if_rdata, if_ack,
      input  d_rdata, d_ack,
      input  stall,
      input  mem_read, mem_write, mem_addr, mem_wdata,
      input  err
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one memory port between an instruction-fetch requester and a
// byte-wide data requester. One access is in flight at a time:
//
//   IDLE  -> sample requests, pick a winner, capture its address/data/op
//   D_ACC -> data access on the memory port
//   I_ACC -> fetch access on the memory port (always a read, wdata 0)
//   RESP  -> one-cycle ack to the winner, then back to IDLE
//
// Data normally wins a collision; if data also won the previous grant the
// fetch goes first, so two continuously pending requesters alternate.
// The first ACC cycle issues the access and ignores mem_busy; any later ACC
// edge with mem_busy low completes it. Best case is 3 cycles from the
// request being sampled in IDLE to the ack.
//
// Parameters
//   ADDR_W    memory byte-address width (must match the interface instance)
//   TIMEOUT   maximum ACC cycles per access, only used with the timeout build
//
// Ports
//   CLK       single clock, rising edge
//   RESET     asynchronous, active-low reset; aborts any access without ack
//   bus       mem_port_arbiter_if.slave (fetch port, data port, stall,
//             shared memory port, err)
//
// Build option
//   MEM_ARB_TIMEOUT_EN  when defined, an access still busy after TIMEOUT ACC
//                       cycles is abandoned: strobes drop, the requester is
//                       acked with read data 0, and err is set until reset.
//                       When undefined the arbiter waits forever, err is 0.
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
   parameter int ADDR_W  = 10,
   parameter int TIMEOUT = 255
) (
   input  logic              CLK,
   input  logic              RESET,
   mem_port_arbiter_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      D_ACC = 2'd1,
      I_ACC = 2'd2,
      RESP  = 2'd3
   } state_t;

   typedef enum logic {
      FETCH = 1'b0,
      DATA  = 1'b1
   } grant_t;

   // A timeout of zero cycles would leave no room for the issue cycle.
   if (TIMEOUT < 1) begin : g_bad_timeout
      $error("mem_port_arbiter: TIMEOUT must be at least 1");
   end

   state_t            state_q,      state_d;
   grant_t            last_grant_q, last_grant_d;
   logic              issue_q,      issue_d;
   logic              mem_read_q,   mem_read_d;
   logic              mem_write_q,  mem_write_d;
   logic [ADDR_W-1:0] mem_addr_q,   mem_addr_d;
   logic [7:0]        mem_wdata_q,  mem_wdata_d;
   logic              if_ack_q,     if_ack_d;
   logic              d_ack_q,      d_ack_d;
   logic [31:0]       if_rdata_q,   if_rdata_d;
   logic [7:0]        d_rdata_q,    d_rdata_d;

   logic              d_pending;
   logic              in_acc;
   logic              done;
   logic              timed_out;
   logic              finish;
   logic [31:0]       rdata_eff;

   assign d_pending = bus.d_read | bus.d_write;
   assign in_acc    = (state_q == D_ACC) || (state_q == I_ACC);

   // The issue cycle never completes; afterwards mem_busy low means done.
   assign done      = in_acc && !issue_q && !bus.mem_busy;

`ifdef MEM_ARB_TIMEOUT_EN
   // Counter width leaves headroom so cnt_q + 1 never wraps before TIMEOUT.
   localparam int CNT_W = $clog2(TIMEOUT + 1) + 1;

   logic [CNT_W-1:0] cnt_q;
   logic             err_q;

   // cnt_q holds the number of ACC cycles already finished, so cnt_q + 1 is
   // the cycle now ending; give up when that reaches TIMEOUT.
   assign timed_out = in_acc && !done && ((cnt_q + 1'b1) >= CNT_W'(TIMEOUT));

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         cnt_q <= '0;
         err_q <= 1'b0;
      end else begin
         if (state_q == IDLE) begin
            // Every ACC entry comes from IDLE, so the count starts fresh.
            cnt_q <= '0;
         end else if (in_acc && !finish) begin
            cnt_q <= cnt_q + 1'b1;
         end
         if (timed_out) begin
            err_q <= 1'b1;
         end
      end
   end

   assign bus.err = err_q;
`else
   assign timed_out = 1'b0;
   assign bus.err   = 1'b0;
`endif

   assign finish    = done | timed_out;

   // An abandoned access returns zero instead of whatever the memory shows.
   assign rdata_eff = timed_out ? 32'd0 : bus.mem_rdata;

   // NOTE: every variable gets its default before the case so no path leaves
   // one unassigned; a missed assignment here would infer a latch.
   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      issue_d      = 1'b0;
      mem_read_d   = mem_read_q;
      mem_write_d  = mem_write_q;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;
      if_ack_d     = 1'b0;
      d_ack_d      = 1'b0;
      if_rdata_d   = if_rdata_q;
      d_rdata_d    = d_rdata_q;

      case (state_q)
         IDLE: begin
            // Data wins unless it also won last time and a fetch is waiting.
            if (d_pending && !(bus.if_req && (last_grant_q == DATA))) begin
               state_d     = D_ACC;
               issue_d     = 1'b1;
               // Read and write together count as a write.
               mem_write_d = bus.d_write;
               mem_read_d  = ~bus.d_write;
               mem_addr_d  = bus.d_addr;
               mem_wdata_d = bus.d_wdata;
            end else if (bus.if_req) begin
               state_d     = I_ACC;
               issue_d     = 1'b1;
               mem_read_d  = 1'b1;
               mem_write_d = 1'b0;
               mem_addr_d  = bus.if_addr;
               mem_wdata_d = 8'd0;
            end
         end

         D_ACC, I_ACC: begin
            if (finish) begin
               state_d     = RESP;
               mem_read_d  = 1'b0;
               mem_write_d = 1'b0;
               if (state_q == I_ACC) begin
                  if_ack_d     = 1'b1;
                  if_rdata_d   = rdata_eff;
                  last_grant_d = FETCH;
               end else begin
                  d_ack_d      = 1'b1;
                  // A write leaves the last read byte in place.
                  if (!mem_write_q) begin
                     d_rdata_d = rdata_eff[7:0];
                  end
                  last_grant_d = DATA;
               end
            end
         end

         RESP: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state_q      <= IDLE;
         last_grant_q <= FETCH;
         issue_q      <= 1'b0;
         mem_read_q   <= 1'b0;
         mem_write_q  <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= 8'd0;
         if_ack_q     <= 1'b0;
         d_ack_q      <= 1'b0;
         if_rdata_q   <= 32'd0;
         d_rdata_q    <= 8'd0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         issue_q      <= issue_d;
         mem_read_q   <= mem_read_d;
         mem_write_q  <= mem_write_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         if_ack_q     <= if_ack_d;
         d_ack_q      <= d_ack_d;
         if_rdata_q   <= if_rdata_d;
         d_rdata_q    <= d_rdata_d;
      end
   end

   assign bus.mem_read  = mem_read_q;
   assign bus.mem_write = mem_write_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;
   assign bus.if_ack    = if_ack_q;
   assign bus.d_ack     = d_ack_q;
   assign bus.if_rdata  = if_rdata_q;
   assign bus.d_rdata   = d_rdata_q;

   // Hold the CPU while a raised request has not yet seen its ack.
   assign bus.stall = (bus.if_req & ~if_ack_q) | (d_pending & ~d_ack_q);

endmodule
